// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side controller for the cascaded 8-bit FIFO.
// A start pulse drains burst_len words from the FIFO read port (1-cycle read
// latency) into a 2-entry skid buffer that feeds a valid/ready stream.
// Optional feature macro: RDR_TIMEOUT_EN. When it is defined, a run of
// TIMEOUT_CYC consecutive empty cycles in READ aborts the burst and raises the
// sticky timeout output.
module fifo_burst_reader #(
    parameter int DATA_W      = 8,
    parameter int LEN_W       = 5,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              empty,
    input  logic [DATA_W-1:0] data_in,
    output logic              r_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_read
`ifdef RDR_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);

    typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

    state_t              state_reg, state_next;
    logic [LEN_W-1:0]    remaining_reg;
    logic [LEN_W-1:0]    words_read_reg;
    logic                rd_inflight_reg;
    logic [DATA_W-1:0]   skid0_reg, skid1_reg, skid0_next, skid1_next;
    logic [1:0]          skid_cnt_reg, skid_cnt_next;
    logic                start_accept;
    logic                push, pop;
    logic                abort_hit;

    assign start_accept = (state_reg == IDLE) && start;

    // Reads are throttled so the skid buffer can always absorb every word in flight.
    assign r_en = (state_reg == READ) && !empty && (remaining_reg != '0) &&
                  ((skid_cnt_reg + {1'b0, rd_inflight_reg}) < 2'd2);

    assign push    = rd_inflight_reg;
    assign m_valid = (skid_cnt_reg != 2'd0);
    assign pop     = m_valid && m_ready;
    assign m_data  = skid0_reg;

    assign busy       = (state_reg == READ) || (state_reg == FLUSH);
    assign done       = (state_reg == DONE);
    assign words_read = words_read_reg;

`ifdef RDR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt_reg;
    logic          timeout_reg;

    assign abort_hit = (state_reg == READ) && empty && (tcnt_reg == TW'(TIMEOUT_CYC - 1));
    assign timeout   = timeout_reg;

    // Count consecutive empty cycles while reading; any data or state change restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (state_reg != READ || !empty)
                tcnt_reg <= '0;
            else
                tcnt_reg <= tcnt_reg + 1'b1;
            if (start_accept)
                timeout_reg <= 1'b0;
            else if (abort_hit)
                timeout_reg <= 1'b1;
        end
    end
`else
    assign abort_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic: READ ends once all reads are issued (or aborted), FLUSH waits for the stream to drain.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = READ;
            READ:    if (remaining_reg == '0 || abort_hit) state_next = FLUSH;
            FLUSH:   if (skid_cnt_reg == 2'd0 && !rd_inflight_reg) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Burst bookkeeping: remaining reads, issued-read counter and the in-flight read flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining_reg   <= '0;
            words_read_reg  <= '0;
            rd_inflight_reg <= 1'b0;
        end else begin
            rd_inflight_reg <= r_en;
            if (start_accept) begin
                remaining_reg  <= burst_len;
                words_read_reg <= '0;
            end else if (abort_hit) begin
                remaining_reg  <= '0;
            end else if (r_en) begin
                remaining_reg  <= remaining_reg - 1'b1;
                words_read_reg <= words_read_reg + 1'b1;
            end
        end
    end

    // Skid update: pop shifts the head out, then the returning read lands in the first free slot.
    always_comb begin
        skid0_next    = skid0_reg;
        skid1_next    = skid1_reg;
        skid_cnt_next = skid_cnt_reg + {1'b0, push} - {1'b0, pop};
        if (pop)
            skid0_next = skid1_reg;
        if (push) begin
            if ((pop && skid_cnt_reg == 2'd1) || (!pop && skid_cnt_reg == 2'd0))
                skid0_next = data_in;
            else
                skid1_next = data_in;
        end
    end

    // Skid buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid0_reg    <= '0;
            skid1_reg    <= '0;
            skid_cnt_reg <= 2'd0;
        end else begin
            skid0_reg    <= skid0_next;
            skid1_reg    <= skid1_next;
            skid_cnt_reg <= skid_cnt_next;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Testbench for fifo_burst_reader: FIFO model with 1-cycle read latency,
// expected stream words queued at stimulus time, monitor pops and compares.
module tb_fifo_burst_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] burst_len = '0;
    logic       empty;
    logic [7:0] data_in = '0;
    logic       r_en;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       busy;
    logic       done;
    logic [4:0] words_read;
`ifdef RDR_TIMEOUT_EN
    logic       timeout;
`endif

    fifo_burst_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .burst_len  (burst_len),
        .empty      (empty),
        .data_in    (data_in),
        .r_en       (r_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .busy       (busy),
        .done       (done),
        .words_read (words_read)
`ifdef RDR_TIMEOUT_EN
        ,
        .timeout    (timeout)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int ren_cnt = 0;
    int held = 0;
    int rdy_mode = 0;          // 0: ready low, 1: ready high, 2: toggle each cycle
    logic [7:0] exp_q[$];

    // FIFO model
    logic [7:0] fmem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (r_en) begin
            data_in <= fmem[rd_ptr % 256];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    // Consumer ready pattern
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = ~m_ready;
        endcase
    end

    // Monitor: stream scoreboard plus read-gating checks
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst) begin
            held = 0;
        end else begin
            if (done) done_cnt++;
            if (r_en) begin
                ren_cnt++;
                n_vec++;
                if (empty || held >= 2) begin
                    n_err++;
                    $display("FAIL ren_gate: r_en=1 with empty=%0b buffered=%0d, required empty=0 buffered<2", empty, held);
                end
            end
            if (m_valid && m_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL stream_extra: got 0x%02h, expected no word", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        n_err++;
                        $display("FAIL stream_data: got 0x%02h, expected 0x%02h", m_data, e);
                    end else begin
                        $display("word 0x%02h ok", m_data);
                    end
                end
            end
            held = held + int'(r_en) - int'(m_valid && m_ready);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("check %s = %0d ok", name, act);
        end
    endtask

    task automatic fpush(input logic [7:0] v);
        fmem[wr_ptr % 256] = v;
        wr_ptr++;
    endtask

    task automatic fclear();
        wr_ptr = rd_ptr;
    endtask

    task automatic go(input logic [4:0] len);
        @(posedge clk); #1;
        start = 1'b1;
        burst_len = len;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = done_cnt;
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk(name, done_cnt - d0, 1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        int r0;
        int k;

        // Reset state
        cycles(2);
        chk("rst_r_en", r_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_words_read", words_read, 0);
        rst = 1'b0;
        cycles(2);

        // 1: eight words, consumer always ready
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) begin
            fpush(8'h11 + 8'(i));
            exp_q.push_back(8'h11 + 8'(i));
        end
        d0 = done_cnt; r0 = ren_cnt;
        go(5'd8);
        wait_done("t1_done", 200);
        chk("t1_words_read", words_read, 8);
        chk("t1_reads", ren_cnt - r0, 8);
        cycles(3);
        chk("t1_done_once", done_cnt - d0, 1);
        chk("t1_drained", exp_q.size(), 0);

        // 2: four words with toggling ready, one extra word left in FIFO
        rdy_mode = 2;
        for (int i = 0; i < 5; i++) fpush(8'h21 + 8'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h21 + 8'(i));
        r0 = ren_cnt;
        go(5'd4);
        wait_done("t2_done", 200);
        chk("t2_words_read", words_read, 4);
        chk("t2_reads", ren_cnt - r0, 4);
        fclear();

        // 3: zero-length burst, done three cycles after start
        rdy_mode = 1;
        fpush(8'h31);
        r0 = ren_cnt;
        cycles(1);
        start = 1'b1;
        burst_len = 5'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t3_busy", busy, 1);
        chk("t3_done_c1", done, 0);
        cycles(1);
        chk("t3_done_c2", done, 0);
        cycles(1);
        chk("t3_done_c3", done, 1);
        cycles(1);
        chk("t3_done_c4", done, 0);
        chk("t3_reads", ren_cnt - r0, 0);
        chk("t3_words_read", words_read, 0);
        fclear();

        // 4: FIFO runs dry mid-burst, refill 20 cycles later
        for (int i = 0; i < 3; i++) fpush(8'h41 + 8'(i));
        for (int i = 0; i < 6; i++) exp_q.push_back(8'h41 + 8'(i));
        d0 = done_cnt;
        go(5'd6);
        cycles(20);
        chk("t4_stall_busy", busy, 1);
        chk("t4_stall_words", words_read, 3);
        for (int i = 3; i < 6; i++) fpush(8'h41 + 8'(i));
        wait_done("t4_done", 200);
        chk("t4_words_read", words_read, 6);
        cycles(3);
        chk("t4_done_once", done_cnt - d0, 1);

        // 5: reset mid-burst with stalled consumer, then resume from next FIFO word
        rdy_mode = 0;
        cycles(2);
        for (int i = 0; i < 5; i++) fpush(8'h51 + 8'(i));
        r0 = ren_cnt;
        go(5'd5);
        k = 0;
        while (words_read != 5'd2 && k < 50) begin cycles(1); k++; end
        cycles(3);
        chk("t5_stall_reads", ren_cnt - r0, 2);
        chk("t5_buffered_valid", m_valid, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_r_en", r_en, 0);
        chk("t5_rst_m_valid", m_valid, 0);
        chk("t5_rst_m_data", m_data, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_words", words_read, 0);
        cycles(1);
        rst = 1'b0;
        rdy_mode = 1;
        exp_q.push_back(8'h53);
        exp_q.push_back(8'h54);
        go(5'd2);
        wait_done("t5_done", 200);
        chk("t5_words_read", words_read, 2);
        fclear();

        // 6: second start while busy is ignored
        for (int i = 0; i < 6; i++) fpush(8'h61 + 8'(i));
        for (int i = 0; i < 3; i++) exp_q.push_back(8'h61 + 8'(i));
        d0 = done_cnt; r0 = ren_cnt;
        go(5'd3);
        start = 1'b1;
        burst_len = 5'd5;
        cycles(1);
        start = 1'b0;
        wait_done("t6_done", 200);
        chk("t6_words_read", words_read, 3);
        cycles(8);
        chk("t6_reads", ren_cnt - r0, 3);
        chk("t6_done_once", done_cnt - d0, 1);
        chk("t6_idle", busy, 0);
        fclear();

        chk("final_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected normal completion");
        $fatal(1);
    end

endmodule
